// File: rtl/cpu7_ifu_fcl.sv
// IFU fetch controller: sequences 64-bit line requests to the ICU, filters
// returned data for the IQ and kills stale fetches when EXU redirects.
module cpu7_ifu_fcl #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exu_ifu_br_taken,
  input  logic [31:0] exu_ifu_br_target,
  input  logic        iq_not_empty,
  input  logic        fetch_ahead,
  input  logic        icu_ifu_ack_ic1,
  input  logic        icu_ifu_data_valid_ic2,
  output logic        ifu_icu_req_ic1,
  output logic [31:0] ifu_icu_addr_ic1,
  output logic        ifu_iq_data_valid,
  output logic        flush_iq,
  output logic        ifu_fetch_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] fetch_addr_q;
  logic [31:0] fetch_addr_d;

  logic flush;
  logic need_fetch;
  logic ack;
  logic data_valid;

  assign flush      = exu_ifu_br_taken;
  assign need_fetch = ~iq_not_empty | fetch_ahead;
  assign ack        = icu_ifu_ack_ic1;
  assign data_valid = icu_ifu_data_valid_ic2;

  // Masking the whole target (rather than slicing [31:3]) keeps every input bit used.
  logic [31:0] redirect_line;
  assign redirect_line = exu_ifu_br_target & ~32'h7;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;

    if (flush) begin
      fetch_addr_d = redirect_line;
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = ack ? DISCARD : REQ;
        WAIT:    state_d = data_valid ? IDLE : DISCARD;
        DISCARD: state_d = data_valid ? IDLE : DISCARD;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (need_fetch) state_d = REQ;
        end
        REQ: begin
          if (ack) begin
            state_d      = WAIT;
            fetch_addr_d = fetch_addr_q + 32'd8;
          end
        end
        WAIT: begin
          if (data_valid) state_d = IDLE;
        end
        DISCARD: begin
          // The line returning here belongs to a killed fetch and is dropped.
          if (data_valid) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_PC;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
    end
  end

  assign ifu_icu_req_ic1   = (state_q == REQ);
  assign ifu_icu_addr_ic1  = fetch_addr_q;
  assign ifu_fetch_busy    = (state_q != IDLE);
  assign flush_iq          = flush;
  assign ifu_iq_data_valid = data_valid & (state_q == WAIT) & ~flush;

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Self-checking bench for cpu7_ifu_fcl: directed scenarios plus a randomized
// run checked against a transaction-level model of the fetch protocol.
module tb_cpu7_ifu_fcl;

  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic        clk;
  logic        resetn;
  logic        br;
  logic [31:0] tgt;
  logic        ne;
  logic        fa;
  logic        ack;
  logic        dv;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic        flush;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  cpu7_ifu_fcl #(.RESET_PC(RESET_PC)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .exu_ifu_br_taken       (br),
    .exu_ifu_br_target      (tgt),
    .iq_not_empty           (ne),
    .fetch_ahead            (fa),
    .icu_ifu_ack_ic1        (ack),
    .icu_ifu_data_valid_ic2 (dv),
    .ifu_icu_req_ic1        (req),
    .ifu_icu_addr_ic1       (addr),
    .ifu_iq_data_valid      (valid),
    .flush_iq               (flush),
    .ifu_fetch_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in protocol terms: a request is being presented, a request
  // has been accepted and its line is outstanding, and whether that line is stale.
  logic        m_req;
  logic        m_out;
  logic        m_stale;
  logic [31:0] m_addr;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_req   <= 1'b0;
      m_out   <= 1'b0;
      m_stale <= 1'b0;
      m_addr  <= RESET_PC;
    end else begin
      if (m_req && ack) begin
        m_req   <= 1'b0;
        m_out   <= 1'b1;
        m_stale <= br;
      end else if (m_out && dv) begin
        m_out   <= 1'b0;
        m_stale <= 1'b0;
      end else if (m_out && br) begin
        m_stale <= 1'b1;
      end
      if (!m_req && !m_out && (br || !ne || fa)) m_req <= 1'b1;
      if (br)                m_addr <= {tgt[31:3], 3'b000};
      else if (m_req && ack) m_addr <= m_addr + 32'd8;
    end
  end

  // Drive one cycle's inputs at the falling edge, then settle before sampling.
  task automatic set_in(input logic i_br, input logic [31:0] i_tgt, input logic i_ne,
                        input logic i_fa, input logic i_ack, input logic i_dv);
    @(negedge clk);
    br  = i_br;
    tgt = i_tgt;
    ne  = i_ne;
    fa  = i_fa;
    ack = i_ack;
    dv  = i_dv;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    br = 1'b0; tgt = 32'h0; ne = 1'b1; fa = 1'b0; ack = 1'b0; dv = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Reset, then request the first line and reach WAIT (addr already advanced).
  task automatic goto_wait();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    set_in(0, 0, 1, 0, 1, 0);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({req, busy, valid, flush} !== 4'b0000 || addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_values: req=%b busy=%b valid=%b flush=%b addr=%h, want 0 0 0 0 %h",
               req, busy, valid, flush, addr, RESET_PC);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic_fetch();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (req !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: req=%b busy=%b, want 0 0", req, busy);
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h1c000000) begin
      n_fail++; $display("FAIL basic_req: req=%b addr=%h, want 1 1c000000", req, addr);
    end
    set_in(0, 0, 1, 0, 1, 0);
    set_in(0, 0, 1, 0, 0, 0);
    n_checks++;
    if (req !== 1'b0 || busy !== 1'b1 || addr !== 32'h1c000008) begin
      n_fail++; $display("FAIL basic_wait: req=%b busy=%b addr=%h, want 0 1 1c000008", req, busy, addr);
    end
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_forward: valid=%b, want 1", valid);
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_single_valid: valid=%b busy=%b, want 0 0", valid, busy);
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h1c000008) begin
      n_fail++; $display("FAIL basic_next_req: req=%b addr=%h, want 1 1c000008", req, addr);
    end
  endtask

  task automatic test_ack_stall();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (req !== 1'b1 || addr !== 32'h1c000000) begin
        n_fail++; $display("FAIL ack_stall[%0d]: req=%b addr=%h, want 1 1c000000", i, req, addr);
      end
    end
  endtask

  task automatic test_flush_in_wait();
    goto_wait();
    set_in(1, 32'h1c000104, 0, 0, 0, 0);
    n_checks++;
    if (flush !== 1'b1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_wait_flush: flush=%b valid=%b, want 1 0", flush, valid);
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (busy !== 1'b1 || req !== 1'b0 || addr !== 32'h1c000100) begin
      n_fail++; $display("FAIL flush_wait_discard: busy=%b req=%b addr=%h, want 1 0 1c000100", busy, req, addr);
    end
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_wait_drop: valid=%b, want 0", valid);
    end
    set_in(0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h1c000100) begin
      n_fail++; $display("FAIL flush_wait_refetch: req=%b addr=%h, want 1 1c000100", req, addr);
    end
  endtask

  task automatic test_flush_with_data();
    goto_wait();
    set_in(1, 32'h1c000200, 0, 0, 0, 1);
    n_checks++;
    if (valid !== 1'b0 || flush !== 1'b1) begin
      n_fail++; $display("FAIL flush_data_drop: valid=%b flush=%b, want 0 1", valid, flush);
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (busy !== 1'b0 || addr !== 32'h1c000200) begin
      n_fail++; $display("FAIL flush_data_idle: busy=%b addr=%h, want 0 1c000200", busy, addr);
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h1c000200) begin
      n_fail++; $display("FAIL flush_data_refetch: req=%b addr=%h, want 1 1c000200", req, addr);
    end
  endtask

  task automatic test_flush_with_ack();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    set_in(1, 32'h1c000010, 0, 0, 1, 0);
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (req !== 1'b0 || busy !== 1'b1 || addr !== 32'h1c000010) begin
      n_fail++; $display("FAIL flush_ack_discard: req=%b busy=%b addr=%h, want 0 1 1c000010", req, busy, addr);
    end
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_ack_drop: valid=%b, want 0", valid);
    end
    set_in(0, 0, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'h1c000010) begin
      n_fail++; $display("FAIL flush_ack_refetch: req=%b addr=%h, want 1 1c000010", req, addr);
    end
  endtask

  task automatic test_wrap_and_hold();
    do_reset();
    set_in(1, 32'hfffffff8, 1, 0, 0, 0);
    set_in(0, 0, 1, 0, 1, 0);
    n_checks++;
    if (req !== 1'b1 || addr !== 32'hfffffff8) begin
      n_fail++; $display("FAIL wrap_req: req=%b addr=%h, want 1 fffffff8", req, addr);
    end
    set_in(0, 0, 1, 0, 0, 1);
    n_checks++;
    if (addr !== 32'h00000000 || valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_addr: addr=%h valid=%b, want 00000000 1", addr, valid);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 1, 0, 0, 0);
      n_checks++;
      if (req !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL hold_no_req[%0d]: req=%b busy=%b, want 0 0", i, req, busy);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    goto_wait();
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || req !== 1'b0 || addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_mid: busy=%b req=%b addr=%h, want 0 0 %h", busy, req, addr, RESET_PC);
    end
    @(negedge clk);
    resetn = 1'b1;
    set_in(0, 0, 1, 0, 0, 1);
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_stale_data: valid=%b busy=%b, want 0 0", valid, busy);
    end
  endtask

  task automatic test_random();
    logic        pend;
    int unsigned lat;
    logic        r_br, r_ack, r_dv;
    logic [31:0] r_tgt;
    pend = 1'b0;
    lat  = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r_br  = ($urandom_range(0, 11) == 0);
      r_tgt = $urandom;
      r_ack = req && ($urandom_range(0, 1) == 1);
      r_dv  = pend ? (lat == 0) : ($urandom_range(0, 39) == 0);
      set_in(r_br, r_tgt, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, r_ack, r_dv);
      n_checks++;
      if (req !== m_req || busy !== (m_req | m_out) || addr !== m_addr ||
          flush !== br || valid !== (dv & m_out & ~m_stale & ~br)) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%b busy=%b addr=%h flush=%b valid=%b, want %b %b %h %b %b",
                 cyc, req, busy, addr, flush, valid, m_req, m_req | m_out, m_addr, br,
                 dv & m_out & ~m_stale & ~br);
      end
      if (req && ack) begin
        pend = 1'b1;
        lat  = $urandom_range(0, 2);
      end else if (pend) begin
        if (dv) pend = 1'b0;
        else    lat  = lat - 1;
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    br = 1'b0; tgt = 32'h0; ne = 1'b1; fa = 1'b0; ack = 1'b0; dv = 1'b0;
    test_reset();
    test_basic_fetch();
    test_ack_stall();
    test_flush_in_wait();
    test_flush_with_data();
    test_flush_with_ack();
    test_wrap_and_hold();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
